// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the PDP-8 memory-reference sequencer.
// Optional feature macro: ALU_SEQ_ISZ_EN (enables the ISZ read/increment/write path).
package alu_seq_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 12;

  // Memory-reference data operations, encoded as issued by the decoder
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_TAD = 2'b01,
    OP_ISZ = 2'b10,
    OP_DCA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EXEC = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  // DCA stores without reading; all other ops fetch the operand first
  function automatic logic needs_read(input logic [1:0] op);
    return op != OP_DCA;
  endfunction

endpackage

// File: rtl/alu_seq_memport.sv
// Memory request holder: captures a request when the FSM issues it and keeps
// REQ/WE/ADDR/WDATA frozen until ACK is sampled, then drops REQ for one cycle
// minimum. ACK seen while REQ is low has no effect.
module alu_seq_memport
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              ack_done
);

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Completion is only meaningful while a request is outstanding
  assign ack_done  = req_q & mem_ack;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Request registers: load on issue, hold until acknowledged; reset drops REQ at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      req_q   <= 1'b1;
      we_q    <= issue_we;
      addr_q  <= issue_addr;
      wdata_q <= issue_wdata;
    end else if (ack_done) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// PDP-8 memory-reference sequencer: owns AC/LINK, fetches operands through
// alu_seq_memport and drives the external 12-bit ADD/AND datapath for
// AND, TAD, ISZ and DCA. Optional ISZ support under macro ALU_SEQ_ISZ_EN;
// without it, ISZ retires immediately with no side effects.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [1:0]        OP,
  input  logic [ADDR_W-1:0] EADDR,
  input  logic              CLR,
  output logic              BUSY,
  output logic              DONE,
  output logic              SKIP,
  output logic [DATA_W-1:0] AC,
  output logic              LINK,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic              ALU_CI,
  output logic              ALU_OE_ADD,
  output logic              ALU_OE_AND,
  input  logic [DATA_W-1:0] ALU_SA,
  input  logic              ALU_CO,
  input  logic [DATA_W-1:0] ALU_SB
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] ea_q;
  logic [DATA_W-1:0] ac_q;
  logic              link_q;
  logic [DATA_W-1:0] m_q;
  logic              skip_q;

  logic              issue;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
  logic              ack_done;

  alu_seq_memport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_memport (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .issue       (issue),
    .issue_we    (issue_we),
    .issue_addr  (issue_addr),
    .issue_wdata (issue_wdata),
    .mem_ack     (MEM_ACK),
    .mem_req     (MEM_REQ),
    .mem_we      (MEM_WE),
    .mem_addr    (MEM_ADDR),
    .mem_wdata   (MEM_WDATA),
    .ack_done    (ack_done)
  );

  assign BUSY = (state_q != S_IDLE);
  assign DONE = (state_q == S_FIN);
  assign SKIP = DONE & skip_q;
  assign AC   = ac_q;
  assign LINK = link_q;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, memory issue and datapath drive. Requests are issued on the
  // transition into RD/WR so REQ is already high in the first RD/WR cycle.
  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = ea_q;
    issue_wdata = ac_q;
    ALU_A       = '0;
    ALU_B       = '0;
    ALU_CI      = 1'b0;
    ALU_OE_ADD  = 1'b0;
    ALU_OE_AND  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (OP == OP_DCA) begin
            state_d     = S_WR;
            issue       = 1'b1;
            issue_we    = 1'b1;
            issue_addr  = EADDR;
            issue_wdata = ac_q;
`ifndef ALU_SEQ_ISZ_EN
          end else if (OP == OP_ISZ) begin
            state_d = S_FIN;
`endif
          end else if (needs_read(OP)) begin
            state_d    = S_RD;
            issue      = 1'b1;
            issue_addr = EADDR;
          end
        end
      end
      S_RD: begin
        if (ack_done) state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_AND: begin
            ALU_A      = ac_q;
            ALU_B      = m_q;
            ALU_OE_AND = 1'b1;
            state_d    = S_FIN;
          end
          OP_TAD: begin
            ALU_A      = ac_q;
            ALU_B      = m_q;
            ALU_OE_ADD = 1'b1;
            state_d    = S_FIN;
          end
`ifdef ALU_SEQ_ISZ_EN
          OP_ISZ: begin
            // Incremented word goes straight into the write request (same value as new M)
            ALU_A       = m_q;
            ALU_CI      = 1'b1;
            ALU_OE_ADD  = 1'b1;
            state_d     = S_WR;
            issue       = 1'b1;
            issue_we    = 1'b1;
            issue_addr  = ea_q;
            issue_wdata = ALU_SA;
          end
`endif
          default: state_d = S_FIN;
        endcase
      end
      S_WR: begin
        if (ack_done) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural and operand registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q   <= OP_AND;
      ea_q   <= '0;
      ac_q   <= '0;
      link_q <= 1'b0;
      m_q    <= '0;
      skip_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            op_q   <= op_e'(OP);
            ea_q   <= EADDR;
            skip_q <= 1'b0;
          end else if (CLR) begin
            ac_q   <= '0;
            link_q <= 1'b0;
          end
        end
        S_RD: begin
          if (ack_done) m_q <= MEM_RDATA;
        end
        S_EXEC: begin
          case (op_q)
            OP_AND: ac_q <= ALU_SB;
            OP_TAD: begin
              ac_q   <= ALU_SA;
              link_q <= link_q ^ ALU_CO;
            end
`ifdef ALU_SEQ_ISZ_EN
            OP_ISZ: begin
              m_q    <= ALU_SA;
              skip_q <= (ALU_SA == '0);
            end
`endif
            default: ;
          endcase
        end
        S_WR: begin
          if (ack_done && op_q == OP_DCA) ac_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed ops push expected retire results and
// memory writes; a DONE monitor and a memory responder pop and compare.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int AW = 12;
  localparam int DW = 12;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic [1:0]    OP = 2'b00;
  logic [AW-1:0] EADDR = '0;
  logic          CLR = 1'b0;
  logic          BUSY, DONE, SKIP, LINK;
  logic [DW-1:0] AC;
  logic          MEM_REQ, MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_ACK = 1'b0;
  logic [DW-1:0] MEM_RDATA = '0;
  logic [DW-1:0] ALU_A, ALU_B, ALU_SA, ALU_SB;
  logic          ALU_CI, ALU_OE_ADD, ALU_OE_AND, ALU_CO;

  alu_seq #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP), .EADDR(EADDR), .CLR(CLR),
    .BUSY(BUSY), .DONE(DONE), .SKIP(SKIP), .AC(AC), .LINK(LINK),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CI(ALU_CI), .ALU_OE_ADD(ALU_OE_ADD),
    .ALU_OE_AND(ALU_OE_AND), .ALU_SA(ALU_SA), .ALU_CO(ALU_CO), .ALU_SB(ALU_SB)
  );

  // Datapath stand-in: results only appear on the enabled function
  logic [DW:0] sum_w;
  assign sum_w  = {1'b0, ALU_A} + {1'b0, ALU_B} + {{DW{1'b0}}, ALU_CI};
  assign ALU_SA = ALU_OE_ADD ? sum_w[DW-1:0] : '0;
  assign ALU_CO = ALU_OE_ADD ? sum_w[DW] : 1'b0;
  assign ALU_SB = ALU_OE_AND ? (ALU_A & ALU_B) : '0;

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] ac;
    logic          link;
    logic          skip;
    int            lat;
    int            oe;
  } exp_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  exp_t          sbq[$];
  wr_t           wq[$];
  logic [DW-1:0] mem [0:4095];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            oe_cnt = 0;
  int            done_cnt = 0;
  int            wait_cycles = 0;
  int            wcnt = 0;
  logic [AW+DW:0] held;
  exp_t          mon_e;
  wr_t           mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // DONE monitor plus per-cycle datapath-enable invariants
  always @(negedge CLK) begin
    if (!RESET_N) begin
      oe_cnt = 0;
    end else begin
      chk("oe_onehot", {31'd0, ALU_OE_ADD & ALU_OE_AND}, 0);
      if (ALU_OE_ADD || ALU_OE_AND) oe_cnt++;
      else chk("alu_idle_zero", {7'd0, ALU_A, ALU_B, ALU_CI}, 0);
      if (DONE) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_ac", {20'd0, AC}, {20'd0, mon_e.ac});
          chk("done_link", {31'd0, LINK}, {31'd0, mon_e.link});
          chk("done_skip", {31'd0, SKIP}, {31'd0, mon_e.skip});
          chk("done_latency", cyc - start_cyc, mon_e.lat);
          chk("oe_cycles", oe_cnt, mon_e.oe);
        end
        oe_cnt = 0;
        done_cnt++;
      end
    end
  end

  // Memory responder: ACK after wait_cycles REQ cycles; checks hold stability and writes
  always @(negedge CLK) begin
    if (MEM_ACK) begin
      chk("req_low_after_ack", {31'd0, MEM_REQ}, 0);
      MEM_ACK = 1'b0;
      wcnt = 0;
    end else if (MEM_REQ) begin
      if (wcnt == 0) held = {MEM_WE, MEM_ADDR, MEM_WDATA};
      else chk("mem_hold", {7'd0, MEM_WE, MEM_ADDR, MEM_WDATA}, {7'd0, held});
      if (wcnt == wait_cycles) begin
        MEM_ACK = 1'b1;
        if (MEM_WE) begin
          if (wq.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
          end else begin
            mon_w = wq.pop_front();
            chk("wr_addr", {20'd0, MEM_ADDR}, {20'd0, mon_w.addr});
            chk("wr_data", {20'd0, MEM_WDATA}, {20'd0, mon_w.data});
          end
          mem[MEM_ADDR] = MEM_WDATA;
        end else begin
          MEM_RDATA = mem[MEM_ADDR];
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Issue one op, push its expectations, wait (bounded) for retirement.
  // inj>0 pulses START and CLR together in that busy cycle.
  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] ea,
                        input logic [DW-1:0] eac, input logic el, input logic esk,
                        input int elat, input int eoe,
                        input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input int inj);
    exp_t e;
    wr_t  w;
    int   d0;
    bit   got;
    e = '{eac, el, esk, elat, eoe};
    sbq.push_back(e);
    if (wr) begin
      w = '{wa, wd};
      wq.push_back(w);
    end
    @(negedge CLK);
    START = 1'b1; OP = op; EADDR = ea;
    start_cyc = cyc;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge CLK);
      START = (i == inj);
      CLR   = (i == inj);
      #1;
      if (done_cnt != d0) got = 1'b1;
    end
    START = 1'b0;
    CLR   = 1'b0;
    chk("op_retired", {31'd0, got}, 1);
  endtask

  task automatic do_clr();
    @(negedge CLK); CLR = 1'b1;
    @(negedge CLK); CLR = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o0100] = 12'o0001;
    mem[12'o0101] = 12'o7777;
    mem[12'o0102] = 12'o5252;
    mem[12'o0103] = 12'o7070;
    mem[12'o0104] = 12'o0005;
    mem[12'o0200] = 12'o7777;
    mem[12'o0300] = 12'o1234;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_flags", {24'd0, BUSY, DONE, SKIP, MEM_REQ, MEM_WE, ALU_OE_ADD, ALU_OE_AND, LINK}, 0);
    chk("rst_ac", {20'd0, AC}, 0);
    chk("rst_mem_bus", {8'd0, MEM_ADDR, MEM_WDATA}, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", {31'd0, BUSY}, 0);

    // TAD carry into LINK, and carry toggling LINK back
    do_clr();
    run_op(OP_TAD, 12'o0101, 12'o7777, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);
    run_op(OP_TAD, 12'o0100, 12'o0000, 1'b1, 1'b0, 3, 1, 0, '0, '0, 0);
    run_op(OP_TAD, 12'o0101, 12'o7777, 1'b1, 1'b0, 3, 1, 0, '0, '0, 0);
    do_clr();
    #1;
    chk("clr_ac", {20'd0, AC}, 0);
    chk("clr_link", {31'd0, LINK}, 0);
    run_op(OP_TAD, 12'o0101, 12'o7777, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);
    run_op(OP_TAD, 12'o0100, 12'o0000, 1'b1, 1'b0, 3, 1, 0, '0, '0, 0);
    run_op(OP_TAD, 12'o0101, 12'o7777, 1'b1, 1'b0, 3, 1, 0, '0, '0, 0);
    run_op(OP_TAD, 12'o0100, 12'o0000, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);

    // AND with 4 wait states; START+CLR while busy must be ignored
    run_op(OP_TAD, 12'o0102, 12'o5252, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);
    wait_cycles = 4;
    run_op(OP_AND, 12'o0103, 12'o5050, 1'b0, 1'b0, 7, 1, 0, '0, '0, 2);
    wait_cycles = 0;

    // ISZ overflow and plain increment
`ifdef ALU_SEQ_ISZ_EN
    run_op(OP_ISZ, 12'o0200, 12'o5050, 1'b0, 1'b1, 4, 1, 1, 12'o0200, 12'o0000, 0);
    run_op(OP_ISZ, 12'o0104, 12'o5050, 1'b0, 1'b0, 4, 1, 1, 12'o0104, 12'o0006, 0);
    chk("isz_mem", {20'd0, mem[12'o0200]}, 0);
`else
    run_op(OP_ISZ, 12'o0200, 12'o5050, 1'b0, 1'b0, 1, 0, 0, '0, '0, 0);
    run_op(OP_ISZ, 12'o0104, 12'o5050, 1'b0, 1'b0, 1, 0, 0, '0, '0, 0);
    chk("isz_mem", {20'd0, mem[12'o0200]}, 12'o7777);
`endif

    // DCA zero-wait and with 2 wait states
    do_clr();
    run_op(OP_TAD, 12'o0300, 12'o1234, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);
    run_op(OP_DCA, 12'o0400, 12'o0000, 1'b0, 1'b0, 2, 0, 1, 12'o0400, 12'o1234, 0);
    chk("dca_mem", {20'd0, mem[12'o0400]}, 12'o1234);
    run_op(OP_TAD, 12'o0300, 12'o1234, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);
    wait_cycles = 2;
    run_op(OP_DCA, 12'o0401, 12'o0000, 1'b0, 1'b0, 4, 0, 1, 12'o0401, 12'o1234, 0);
    wait_cycles = 0;

    // Mid-operation reset during RD wait: REQ drops at once, no DONE
    run_op(OP_TAD, 12'o0102, 12'o5252, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);
    wait_cycles = 10;
    @(negedge CLK);
    START = 1'b1; OP = OP_TAD; EADDR = 12'o0101;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    chk("rd_wait_req", {30'd0, MEM_REQ, BUSY}, 3);
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_req_drop", {31'd0, MEM_REQ}, 0);
    chk("async_flags", {26'd0, BUSY, DONE, SKIP, MEM_WE, LINK, ALU_OE_ADD | ALU_OE_AND}, 0);
    chk("async_ac", {20'd0, AC}, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    wait_cycles = 0;
    repeat (3) @(negedge CLK);
    run_op(OP_TAD, 12'o0100, 12'o0001, 1'b0, 1'b0, 3, 1, 0, '0, '0, 0);

    repeat (3) @(negedge CLK);
    chk("sb_empty", sbq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that owns the accumulator and link register and drives the 12-bit ADD/AND datapath to execute PDP-8 memory-reference data operations: AND, TAD, ISZ and DCA. It sits between the instruction decoder, which issues one operation at a time with a start/done handshake, and the memory port, which it accesses through a request/acknowledge interface. It is the only master of the datapath's operand inputs and output enables.

## Interface
- `ADDR_W`, default 12: memory address width.
- `DATA_W`, default 12: word width; must match the datapath.
- `CLK` in 1: sole clock; all state changes on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: issue an operation; sampled only in IDLE.
- `OP` in 2: 00 AND, 01 TAD, 10 ISZ, 11 DCA; sampled with START.
- `EADDR` in ADDR_W: effective address; sampled with START.
- `CLR` in 1: clear AC and L; honoured only in IDLE without START.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse when the operation retires.
- `SKIP` out 1: valid with DONE; high when the ISZ result is 0000.
- `AC` out DATA_W: accumulator.
- `LINK` out 1: link bit.
- `MEM_REQ` out 1, `MEM_WE` out 1, `MEM_ADDR` out ADDR_W, `MEM_WDATA` out DATA_W: memory request.
- `MEM_ACK` in 1, `MEM_RDATA` in DATA_W: memory acknowledge; read data is valid with ACK.
- `ALU_A` out DATA_W, `ALU_B` out DATA_W, `ALU_CI` out 1, `ALU_OE_ADD` out 1, `ALU_OE_AND` out 1: datapath controls.
- `ALU_SA` in DATA_W, `ALU_CO` in 1, `ALU_SB` in DATA_W: datapath results. SA and CO are the sum and carry-out; SB is the AND result.

## Operation
- States: IDLE, RD, EXEC, WR, FIN.
- IDLE with START:
  - AND, TAD and ISZ go to RD.
  - DCA goes to WR.
  - OP and EADDR are latched into internal registers.
- RD: assert MEM_REQ with MEM_WE=0 and MEM_ADDR=EADDR. On MEM_ACK, capture MEM_RDATA into operand register M and go to EXEC.
- EXEC lasts exactly one cycle and asserts exactly one datapath enable.
  - AND: ALU_A=AC, ALU_B=M, OE_AND=1. AC ← SB. Go to FIN.
  - TAD: ALU_A=AC, ALU_B=M, CI=0, OE_ADD=1. AC ← SA. LINK ← LINK ^ CO. Go to FIN.
  - ISZ: ALU_A=M, ALU_B=0, CI=1, OE_ADD=1. M ← SA. The skip flag is set when SA==0. Go to WR.
- WR: assert MEM_REQ with MEM_WE=1. MEM_WDATA is AC for DCA and M for ISZ. On MEM_ACK go to FIN. DCA also clears AC to 0 at ACK.
- FIN: pulse DONE, drive SKIP, return to IDLE.
- Memory handshake:
  - REQ, WE, ADDR and WDATA are held stable until ACK is sampled high.
  - REQ is low in the cycle after ACK.
  - ACK while REQ is low is ignored.
  - Wait states are unbounded; there is no timeout.
- ALU_OE_ADD and ALU_OE_AND are both 0 outside EXEC. ALU_A, ALU_B and ALU_CI are 0 outside EXEC.
- CLR in IDLE: AC ← 0, LINK ← 0. CLR is ignored when BUSY or when START is high in the same cycle; START wins.
- START while BUSY is ignored; nothing is queued.
- Arithmetic is modulo 2^DATA_W. ISZ of 7777 gives 0000 with SKIP=1. ISZ never changes LINK.

## Timing
- Reset values: state IDLE, AC=0, LINK=0, and every output 0, including BUSY, DONE, SKIP, MEM_REQ and both OE signals.
- Asserting RESET_N low mid-operation drops MEM_REQ immediately (asynchronously). The operation is abandoned with no DONE.
- Latency from START to DONE, assuming zero-wait ACK (ACK in the first REQ cycle):
  - AND and TAD: 3 cycles.
  - ISZ: 4 cycles.
  - DCA: 2 cycles.
  - Each ACK wait cycle adds 1.
- Back-to-back operations: START is accepted in the cycle after DONE.
- BUSY rises in the cycle after START is accepted and falls together with the DONE cycle's exit.

## Configuration
- `ALU_SEQ_ISZ_EN` defined: ISZ behaves as above.
- Undefined: OP=10 goes IDLE → FIN. There is no memory access, AC and LINK are unchanged, SKIP=0, and DONE arrives 1 cycle after START. The ISZ paths in EXEC and WR are not compiled.

## Structure
- Package `alu_seq_pkg`:
  - Op encodings OP_AND, OP_TAD, OP_ISZ, OP_DCA.
  - State enum for IDLE, RD, EXEC, WR, FIN.
  - Default width constants.
- Sub-module `alu_seq_memport`: holds REQ, WE, ADDR and WDATA stable until ACK, and flags acknowledge completion to the FSM. The FSM, the AC/LINK/M registers and the datapath drive stay in `alu_seq`.

## Test plan
- TAD carry: set AC=7777 (octal) and LINK=0, with M[0100]=0001. OP=TAD at 0100, zero-wait ACK → DONE 3 cycles after START, AC=0000, LINK=1.
- AND with wait states: AC=5252, M=7070, ACK delayed 4 cycles → AC=5050. MEM_REQ and MEM_ADDR stay stable through the wait. DONE arrives 7 cycles after START.
- ISZ overflow: M[0200]=7777 → write of 0000 to 0200, SKIP=1 with DONE, AC and LINK unchanged. With the macro undefined, ISZ instead gives no memory traffic and DONE after 1 cycle.
- DCA: AC=1234 → write of 1234 to EADDR, AC=0 after ACK, DONE 2 cycles after START.
- Mid-operation reset and ignored requests:
  - Drop RESET_N during RD wait → MEM_REQ falls immediately, all outputs 0, no DONE.
  - A subsequent TAD executes normally.
- Datapath enables: assert START and CLR while BUSY → both ignored. Across all ops, never more than one OE high, and OEs are high only in the single EXEC cycle.
